// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: forwarding select
// encoding (also used by the EX-stage operand MUX3_1) and the stage record.
package hazard_fwd_unit_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FWD_SEL_W = 2;
  localparam int unsigned CNT_W     = 32;

  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } stage_rec_t;

  // True when a stage record will write the given source register (x0 never matches).
  function automatic logic producer_match(input stage_rec_t rec,
                                          input logic [REG_IDX_W-1:0] src);
    return rec.valid && rec.regwrite && (rec.rd != '0) && (rec.rd == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel_calc.sv
// Combinational forwarding select for one source index against the EX and MEM records.
module fwd_sel_calc
  import hazard_fwd_unit_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_i,
  input  stage_rec_t           ex_i,
  input  stage_rec_t           mem_i,
  output logic [FWD_SEL_W-1:0] sel_c
);

  // Load flags are irrelevant to selection; the load-use case is handled by the stall.
  logic unused_memread;
  assign unused_memread = ex_i.memread ^ mem_i.memread;

  // Nearest producer wins: EX moves to MEM while the consumer moves to EX.
  always_comb begin
    sel_c = FWD_RF;
    if (producer_match(ex_i, src_i)) begin
      sel_c = FWD_MEM;
    end else if (producer_match(mem_i, src_i)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection and EX-stage operand forwarding selects.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_regwrite_i,
  input  logic                 id_memread_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [FWD_SEL_W-1:0] fwd_a_o,
  output logic [FWD_SEL_W-1:0] fwd_b_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt_o
`endif
);

  stage_rec_t           ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic [FWD_SEL_W-1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic [FWD_SEL_W-1:0] sel_a_c, sel_b_c;
  logic                 stall_c;
  logic                 capture_c;

  fwd_sel_calc u_sel_rs1 (
    .src_i (id_rs1_i),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_c (sel_a_c)
  );

  fwd_sel_calc u_sel_rs2 (
    .src_i (id_rs2_i),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_c (sel_b_c)
  );

  // Load in EX feeding the ID instruction; a taken flush overrides it.
  always_comb begin
    stall_c = 1'b0;
    if (id_valid_i && !flush_i && ex_q.valid && ex_q.memread &&
        (producer_match(ex_q, id_rs1_i) || producer_match(ex_q, id_rs2_i))) begin
      stall_c = 1'b1;
    end
  end

  assign capture_c = id_valid_i && !flush_i && !stall_c;

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    mem_d   = ex_q;
    wb_d    = mem_q;
    if (capture_c) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
      fwd_a_d       = sel_a_c;
      fwd_b_d       = sel_b_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // WB producers reach the consumer through the register file's write-before-read.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign stall_o = stall_c;
  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed hazard scenarios plus random traffic
// against a producer-history reference model (define HAZ_PERF_CNT_EN to cover the counter).
module tb_hazard_fwd_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, flush;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  hazard_fwd_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .stall_o       (stall),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt)
`endif
  );

`ifndef HAZ_PERF_CNT_EN
  assign stall_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit rw; bit ld; bit fl;
  } instr_t;

  typedef struct {
    bit v; int rd; bit rw; bit ld;
  } prod_t;

  typedef struct {
    bit          st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  exp_t  sbq[$];
  prod_t hist[$];   // hist[0] = instruction now in EX, hist[1] = in MEM
  int    m_fa, m_fb;
  longint m_cnt;
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit writes(input prod_t p, input int r);
    return p.v && p.rw && (p.rd != 0) && (p.rd == r);
  endfunction

  // Distance to the nearest in-flight writer: one ahead -> MEM ALU result, two -> WB result.
  function automatic int nearest(input int r);
    for (int k = 0; k < 2; k++)
      if (writes(hist[k], r)) return (k == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic void model_reset();
    prod_t empty;
    empty = '{v: 0, rd: 0, rw: 0, ld: 0};
    hist.delete();
    hist.push_back(empty);
    hist.push_back(empty);
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endfunction

  function automatic bit model_step(input instr_t i);
    exp_t  e;
    prod_t p;
    bit    st, take;
    st = i.v && !i.fl && hist[0].v && hist[0].ld &&
         (writes(hist[0], i.rs1) || writes(hist[0], i.rs2));
    e.st = st; e.fa = 2'(m_fa); e.fb = 2'(m_fb); e.cnt = 32'(m_cnt);
    sbq.push_back(e);
    take = i.v && !i.fl && !st;
    m_fa = take ? nearest(i.rs1) : 0;
    m_fb = take ? nearest(i.rs2) : 0;
    p = '{v: take, rd: take ? i.rd : 0, rw: take && i.rw, ld: take && i.ld};
    hist.push_front(p);
    void'(hist.pop_back());
    if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    return st;
  endfunction

  task automatic drive(input instr_t i);
    id_valid    = i.v;
    id_rd       = 5'(i.rd);
    id_rs1      = 5'(i.rs1);
    id_rs2      = 5'(i.rs2);
    id_regwrite = i.rw;
    id_memread  = i.ld;
    flush       = i.fl;
  endtask

  function automatic instr_t mk(input bit v, input int rd, input int rs1, input int rs2,
                                input bit rw, input bit ld, input bit fl);
    instr_t i;
    i = '{v: v, rd: rd, rs1: rs1, rs2: rs2, rw: rw, ld: ld, fl: fl};
    return i;
  endfunction

  // One ID instruction; re-presented while the model says it is stalled.
  task automatic issue(input instr_t i);
    bit st;
    int guard = 0;
    do begin
      @(posedge clk); #1;
      drive(i);
      st = model_step(i);
      guard++;
    end while (st && guard < 4);
    if (st) check("stall_bounded", 1, 0);
  endtask

  task automatic issue_once(input instr_t i);
    bit st;
    @(posedge clk); #1;
    drive(i);
    st = model_step(i);
  endtask

  // Monitor: DUT presents stall/fwd every cycle; compare against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sbq.size() > 0) begin
      e = sbq.pop_front();
      check("stall_o", longint'(stall), longint'(e.st));
      check("fwd_a_o", longint'(fwd_a), longint'(e.fa));
      check("fwd_b_o", longint'(fwd_b), longint'(e.fb));
`ifdef HAZ_PERF_CNT_EN
      check("stall_cnt_o", longint'(stall_cnt), longint'(e.cnt));
`endif
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", longint'(stall), 0);
    check("rst_fwd_a", longint'(fwd_a), 0);
    check("rst_fwd_b", longint'(fwd_b), 0);
    check("rst_cnt", longint'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    repeat (3) issue(mk(0, 0, 0, 0, 0, 0, 0));
    while (sbq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() > 0) check("scoreboard_drain", sbq.size(), 0);
  endtask

  initial begin
    instr_t ri;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    apply_reset();

    // add x5 ; add x6,x5,x1 -> fwd_a=MEM
    issue(mk(1, 5, 1, 2, 1, 0, 0));
    issue(mk(1, 6, 5, 1, 1, 0, 0));
    // add x5 ; nop ; sub x7,x2,x5 -> fwd_b=WB
    issue(mk(1, 5, 3, 4, 1, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 0, 0));
    issue(mk(1, 7, 2, 5, 1, 0, 0));
    // lw x8 ; add x9,x8,x8 -> one stall then both WB
    issue(mk(1, 8, 1, 0, 1, 1, 0));
    issue(mk(1, 9, 8, 8, 1, 0, 0));
    // lw x8 ; consumer with flush -> no stall, bubble
    issue(mk(1, 8, 1, 0, 1, 1, 0));
    issue(mk(1, 9, 8, 8, 1, 0, 1));
    issue(mk(0, 0, 0, 0, 0, 0, 0));
    // writes to x0 never forward; add x5 twice -> nearest wins
    issue(mk(1, 0, 1, 2, 1, 0, 0));
    issue(mk(1, 3, 0, 0, 1, 1, 0));
    issue(mk(1, 4, 0, 0, 1, 0, 0));
    issue(mk(1, 5, 1, 2, 1, 0, 0));
    issue(mk(1, 5, 3, 4, 1, 0, 0));
    issue(mk(1, 10, 5, 5, 1, 0, 0));
    drain();

    // Reset asserted mid-stall drops stall_o immediately.
    issue(mk(1, 8, 1, 0, 1, 1, 0));
    issue_once(mk(1, 9, 8, 2, 1, 0, 0));
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", longint'(stall), 0);
    check("rst_mid_fwd_a", longint'(fwd_a), 0);
    apply_reset();

    // Three load-use pairs from a clean counter.
    for (int k = 0; k < 3; k++) begin
      issue(mk(1, 8 + k, 1, 0, 1, 1, 0));
      issue(mk(1, 12, 2, 8 + k, 1, 0, 0));
    end
    drain();
`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt_3", longint'(stall_cnt), 3);
`endif

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      ri.v   = ($urandom_range(0, 99) < 85);
      ri.rd  = int'($urandom_range(0, 7));
      ri.rs1 = int'($urandom_range(0, 7));
      ri.rs2 = int'($urandom_range(0, 7));
      ri.rw  = ($urandom_range(0, 99) < 80);
      ri.ld  = ($urandom_range(0, 99) < 35);
      ri.fl  = ($urandom_range(0, 99) < 10);
      issue(ri);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
